wshb_fb_slave: RTL and testbench

WSHB_FB_SLAVE -- requirements
Module: wshb_fb_slave

---
 rtl/wshb_fb_slave_if.sv | 29 ++
 rtl/wshb_fb_slave.sv | 130 +++++++++++++
 tb/tb_wshb_fb_slave.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/wshb_fb_slave_if.sv
// Team Wishbone bus bundle (interface wshb_if): 32-bit data, byte enables,
// registered-feedback burst tags, plus the clock and synchronous active-high reset.
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        input  clk, rst, dat_sm, ack, err, rty,
        output adr, dat_ms, sel, we, cyc, stb, cti, bte
    );

    modport slave (
        input  clk, rst, adr, dat_ms, sel, we, cyc, stb, cti, bte,
        output dat_sm, ack, err, rty
    );
endinterface

// File: rtl/wshb_fb_slave.sv
// Wishbone framebuffer slave: DEPTH x 32 RAM with classic single-beat access
// and zero-wait-state incrementing bursts driven by a prefetching read port.
module wshb_fb_slave #(
    parameter int DEPTH = 1024,
    parameter int HDISP = 800
) (
    wshb_if.slave wshb_ifs,
    output logic  line_end
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (HDISP > 1) ? $clog2(HDISP) : 1;

    typedef enum logic [1:0] {IDLE, CLASSIC, BURST, ERR} state_t;

    logic [31:0]   mem [DEPTH];
    state_t        state;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] col_q;
    logic          ack_q;
    logic          err_q;
    logic          we_q;
    logic [31:0]   dat_q;

    logic [29:0]   req_idx;
    logic          req;
    logic          beat;
    logic          in_range;
    logic          we_ok;
    logic          mem_we;
    logic [AW-1:0] addr_nxt;
    logic [CW-1:0] col_init;
    logic [CW-1:0] col_nxt;
    logic          unused_adr;

    assign req_idx    = wshb_ifs.adr[31:2];
    assign unused_adr = ^wshb_ifs.adr[1:0];
    assign req        = wshb_ifs.cyc & wshb_ifs.stb;
    assign in_range   = req_idx < 30'(DEPTH);
    assign beat       = ack_q & req;
    assign we_ok      = (wshb_ifs.we == we_q);
    // A beat whose we disagrees with the accepted direction never touches memory.
    assign mem_we     = beat & we_q & we_ok & ~wshb_ifs.rst;
    assign addr_nxt   = addr_q + AW'(1);
    assign col_init   = CW'(32'(req_idx[AW-1:0]) % 32'(HDISP));
    assign col_nxt    = (col_q == CW'(HDISP - 1)) ? '0 : col_q + CW'(1);

    assign wshb_ifs.ack    = beat;
    assign wshb_ifs.err    = err_q & req;
    assign wshb_ifs.rty    = 1'b0;
    assign wshb_ifs.dat_sm = dat_q;
    assign line_end        = beat & (col_q == CW'(HDISP - 1));

    always_ff @(posedge wshb_ifs.clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wshb_ifs.sel[i]) mem[addr_q][8*i +: 8] <= wshb_ifs.dat_ms[8*i +: 8];
            end
        end
    end

    always_ff @(posedge wshb_ifs.clk) begin
        if (wshb_ifs.rst) begin
            state  <= IDLE;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            dat_q  <= '0;
            addr_q <= '0;
            col_q  <= '0;
            we_q   <= 1'b0;
        end else if (!wshb_ifs.cyc) begin
            state <= IDLE;
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wshb_ifs.stb) begin
                        addr_q <= req_idx[AW-1:0];
                        col_q  <= col_init;
                        we_q   <= wshb_ifs.we;
                        if (!in_range) begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end else begin
                            dat_q <= mem[req_idx[AW-1:0]];
                            ack_q <= 1'b1;
                            if (wshb_ifs.cti == 3'b010 && wshb_ifs.bte == 2'b00) state <= BURST;
                            else                                                 state <= CLASSIC;
                        end
                    end
                end
                CLASSIC: begin
                    if (beat) begin
                        state <= IDLE;
                        ack_q <= 1'b0;
                    end
                end
                BURST: begin
                    // Each beat prefetches the next word so reads stream with no wait states.
                    if (beat) begin
                        if (!we_ok) begin
                            state <= ERR;
                            ack_q <= 1'b0;
                            err_q <= 1'b1;
                        end else if (wshb_ifs.cti == 3'b111) begin
                            state <= IDLE;
                            ack_q <= 1'b0;
                        end else if (addr_q == AW'(DEPTH - 1)) begin
                            state  <= ERR;
                            ack_q  <= 1'b0;
                            err_q  <= 1'b1;
                            addr_q <= '0;
                        end else begin
                            addr_q <= addr_nxt;
                            col_q  <= col_nxt;
                            dat_q  <= mem[addr_nxt];
                        end
                    end
                end
                ERR: begin
                    if (wshb_ifs.stb) begin
                        state <= IDLE;
                        err_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wshb_fb_slave.sv
// Self-checking bench for wshb_fb_slave: table-driven classic accesses plus
// hand-written burst, pause, overflow, direction-change and mid-burst reset sequences.
module tb_wshb_fb_slave;
    localparam int DEPTH = 64;
    localparam int HDISP = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic line_end;
    always #5 clk = ~clk;

    wshb_if bus (.clk(clk), .rst(rst));

    wshb_fb_slave #(.DEPTH(DEPTH), .HDISP(HDISP)) dut (
        .wshb_ifs (bus.slave),
        .line_end (line_end)
    );

    typedef struct {
        logic        w;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
        logic        exp_err;
    } vec_t;

    vec_t        vt [15];
    logic [31:0] model [DEPTH];
    logic [31:0] sbq [$];
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic void model_wr(input int idx, input logic [31:0] d, input logic [3:0] s);
        for (int i = 0; i < 4; i++) begin
            if (s[i]) model[idx][8*i +: 8] = d[8*i +: 8];
        end
    endfunction

    task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic ga, output logic ge,
                           output logic [31:0] rd, output int lat, output logic le);
        @(posedge clk); #1;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = w; bus.adr = a;
        bus.dat_ms = d; bus.sel = s; bus.cti = 3'b000; bus.bte = 2'b00;
        lat = 0; ga = 1'b0; ge = 1'b0; rd = '0; le = 1'b0;
        while (!ga && !ge && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            ga = bus.ack; ge = bus.err; rd = bus.dat_sm; le = line_end;
            check("ack_err_excl", bus.ack & bus.err, 1'b0);
        end
        @(posedge clk); #1;
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd_check(input int idx, input string nm);
        logic ga, ge, le;
        logic [31:0] rd, exp;
        int lat;
        sbq.push_back(model[idx]);
        classic(1'b0, 32'(idx * 4), 32'h0, 4'hF, ga, ge, rd, lat, le);
        exp = sbq.pop_front();
        check({nm, "_ack"}, ga, 1'b1);
        check({nm, "_lat"}, lat, 1);
        if (ga) check({nm, "_data"}, rd, exp);
    endtask

    task automatic burst_rd(input int start, input int n, input int pause_after, input int pause_len,
                            input int exp_acks, input logic exp_err);
        int beats, paused, cycles;
        logic seen_err;
        logic [31:0] exp;
        for (int i = 0; i < n; i++) begin
            if (start + i < DEPTH) sbq.push_back(model[start + i]);
        end
        @(posedge clk); #1;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'(start * 4);
        bus.sel = 4'hF; bus.bte = 2'b00; bus.cti = (n == 1) ? 3'b111 : 3'b010;
        @(posedge clk);
        beats = 0; paused = 0; cycles = 0; seen_err = 1'b0;
        while (beats < n && !seen_err && cycles < 64) begin
            #1;
            bus.stb = !(beats == pause_after && paused < pause_len);
            bus.cti = (beats == n - 1) ? 3'b111 : 3'b010;
            #1;
            cycles++;
            check("burst_excl", bus.ack & bus.err, 1'b0);
            if (!bus.stb) begin
                paused++;
                check("pause_ack", bus.ack, 1'b0);
                if (sbq.size() > 0) check("pause_hold", bus.dat_sm, sbq[0]);
            end else if (bus.err) begin
                seen_err = 1'b1;
            end else if (bus.ack) begin
                exp = (sbq.size() > 0) ? sbq.pop_front() : 32'hDEAD_BEEF;
                check($sformatf("burst_data[%0d]", start + beats), bus.dat_sm, exp);
                check($sformatf("burst_le[%0d]", start + beats), line_end,
                      ((start + beats) % HDISP) == HDISP - 1);
                beats++;
            end else begin
                check("burst_wait", bus.ack, 1'b1);
            end
            @(posedge clk);
        end
        #1; #1;
        check("burst_end_ack", bus.ack, 1'b0);
        check("burst_end_err", bus.err, 1'b0);
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.cti = 3'b000;
        check("burst_beats", beats, exp_acks);
        check("burst_err_seen", seen_err, exp_err);
        check("burst_cycles", cycles, exp_acks + pause_len + (exp_err ? 1 : 0));
        check("burst_sb_empty", sbq.size(), 0);
        sbq.delete();
    endtask

    initial begin
        logic ga, ge, le;
        logic [31:0] rd, exp;
        int lat;

        vt[0]  = '{1'b1, 32'h08, 32'h1234_5678, 4'hF, 32'h0, 1'b0};
        vt[1]  = '{1'b1, 32'h10, 32'hA5A5_1234, 4'hF, 32'h0, 1'b0};
        vt[2]  = '{1'b0, 32'h10, 32'h0,         4'hF, 32'hA5A5_1234, 1'b0};
        vt[3]  = '{1'b0, 32'h13, 32'h0,         4'hF, 32'hA5A5_1234, 1'b0};
        vt[4]  = '{1'b1, 32'h20, 32'h0,         4'hF, 32'h0, 1'b0};
        vt[5]  = '{1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0010, 32'h0, 1'b0};
        vt[6]  = '{1'b0, 32'h20, 32'h0,         4'hF, 32'h0000_FF00, 1'b0};
        vt[7]  = '{1'b1, 32'h24, 32'hCAFE_BABE, 4'hF, 32'h0, 1'b0};
        vt[8]  = '{1'b1, 32'h24, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0};
        vt[9]  = '{1'b0, 32'h24, 32'h0,         4'hF, 32'hCAFE_BABE, 1'b0};
        vt[10] = '{1'b1, 32'h24, 32'h5566_7788, 4'b1001, 32'h0, 1'b0};
        vt[11] = '{1'b0, 32'h24, 32'h0,         4'hF, 32'h55FE_BA88, 1'b0};
        vt[12] = '{1'b0, 32'(4 * DEPTH),     32'h0,         4'hF, 32'h0, 1'b1};
        vt[13] = '{1'b1, 32'(4 * DEPTH + 8), 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
        vt[14] = '{1'b0, 32'h08, 32'h0,         4'hF, 32'h1234_5678, 1'b0};

        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.adr = '0;
        bus.dat_ms = '0; bus.sel = '0; bus.cti = '0; bus.bte = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_ack", bus.ack, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_rty", bus.rty, 1'b0);
        check("rst_dat", bus.dat_sm, 32'h0);
        check("rst_line_end", line_end, 1'b0);

        for (int k = 0; k < 15; k++) begin
            if (!vt[k].w && !vt[k].exp_err) sbq.push_back(vt[k].exp);
            classic(vt[k].w, vt[k].adr, vt[k].dat, vt[k].sel, ga, ge, rd, lat, le);
            check($sformatf("tbl_err[%0d]", k), ge, vt[k].exp_err);
            check($sformatf("tbl_ack[%0d]", k), ga, !vt[k].exp_err);
            check($sformatf("tbl_lat[%0d]", k), lat, 1);
            if (!vt[k].exp_err) begin
                check($sformatf("tbl_le[%0d]", k), le, ((vt[k].adr >> 2) % HDISP) == HDISP - 1);
                if (vt[k].w) begin
                    model_wr(int'(vt[k].adr >> 2), vt[k].dat, vt[k].sel);
                end else begin
                    exp = sbq.pop_front();
                    if (ga) check($sformatf("tbl_rdata[%0d]", k), rd, exp);
                end
            end
        end

        for (int i = 0; i < 16; i++) begin
            classic(1'b1, 32'(i * 4), 32'(i), 4'hF, ga, ge, rd, lat, le);
            model_wr(i, 32'(i), 4'hF);
        end
        for (int i = DEPTH - 2; i < DEPTH; i++) begin
            classic(1'b1, 32'(i * 4), 32'hBEEF_0000 | 32'(i), 4'hF, ga, ge, rd, lat, le);
            model_wr(i, 32'hBEEF_0000 | 32'(i), 4'hF);
        end

        burst_rd(0, 8, -1, 0, 8, 1'b0);
        burst_rd(0, 8, 2, 3, 8, 1'b0);
        burst_rd(5, 8, -1, 0, 8, 1'b0);
        burst_rd(DEPTH - 2, 4, -1, 0, 2, 1'b1);

        // Write burst from word 1; reset lands on beat 4 (word 4).
        @(posedge clk); #1;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 32'h4;
        bus.sel = 4'hF; bus.cti = 3'b010; bus.bte = 2'b00; bus.dat_ms = 32'h101;
        @(posedge clk);
        for (int b = 0; b < 4; b++) begin
            #1;
            bus.dat_ms = 32'h101 + 32'(b);
            if (b == 3) rst = 1'b1;
            #1;
            check($sformatf("wburst_ack[%0d]", b), bus.ack, 1'b1);
            @(posedge clk);
        end
        #1 rst = 1'b0;
        #1;
        check("rst_mid_ack", bus.ack, 1'b0);
        check("rst_mid_err", bus.err, 1'b0);
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.cti = 3'b000;
        for (int b = 0; b < 3; b++) model_wr(1 + b, 32'h101 + 32'(b), 4'hF);
        rd_check(4, "rst_word4");
        rd_check(3, "rst_word3");
        classic(1'b1, 32'h10, 32'h0000_0044, 4'hF, ga, ge, rd, lat, le);
        model_wr(4, 32'h0000_0044, 4'hF);
        check("post_rst_wr_ack", ga, 1'b1);
        rd_check(4, "post_rst_rd");

        // Direction change on the second beat of a read burst.
        @(posedge clk); #1;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h0;
        bus.sel = 4'hF; bus.cti = 3'b010; bus.bte = 2'b00; bus.dat_ms = 32'hFFFF_FFFF;
        @(posedge clk);
        #2;
        check("wechg_beat1", bus.ack, 1'b1);
        @(posedge clk); #1;
        bus.we = 1'b1;
        @(posedge clk); #2;
        check("wechg_err", bus.err, 1'b1);
        check("wechg_noack", bus.ack, 1'b0);
        @(posedge clk); #1;
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.cti = 3'b000;
        rd_check(1, "wechg_word1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
